// File: rtl/om_range_table.sv
// rtl/om_range_table.sv - table of inclusive address ranges with insert, free-by-base and registered lookup
// Optional last-insert readback ports are enabled by defining OM_RT_READBACK_EN.
module om_range_table #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 32,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              ins_valid_i,
    input  logic [ADDR_W-1:0] ins_first_i,
    input  logic [ADDR_W-1:0] ins_last_i,
    output logic              ins_err_o,
    input  logic              free_valid_i,
    input  logic [ADDR_W-1:0] free_first_i,
    output logic              free_miss_o,
    input  logic              q_valid_i,
    input  logic [ADDR_W-1:0] q_addr_i,
    output logic              r_valid_o,
    output logic              r_hit_o,
    output logic [IDX_W-1:0]  r_idx_o,
    output logic [ADDR_W-1:0] r_first_o,
    output logic [ADDR_W-1:0] r_last_o,
`ifdef OM_RT_READBACK_EN
    output logic [ADDR_W-1:0] last_first_o,
    output logic [ADDR_W-1:0] last_last_o,
`endif
    output logic [IDX_W:0]    count_o,
    output logic              full_o,
    output logic              ovf_o
);

    logic [ADDR_W-1:0] first_q [DEPTH];
    logic [ADDR_W-1:0] first_d [DEPTH];
    logic [ADDR_W-1:0] last_q  [DEPTH];
    logic [ADDR_W-1:0] last_d  [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [IDX_W-1:0]  cursor_q, cursor_d;
    logic [IDX_W:0]    count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              ins_err_q, ins_err_d;
    logic              free_miss_q, free_miss_d;
    logic              r_valid_q, r_valid_d;
    logic              r_hit_q, r_hit_d;
    logic [IDX_W-1:0]  r_idx_q, r_idx_d;
    logic [ADDR_W-1:0] r_first_q, r_first_d;
    logic [ADDR_W-1:0] r_last_q, r_last_d;

    logic              ins_ok, free_act;
    logic [DEPTH-1:0]  free_hits;
    logic              found;

    assign ins_ok   = ins_valid_i && (ins_last_i >= ins_first_i) && !clear_i;
    assign free_act = free_valid_i && !clear_i;

    // Table update: free matching and overwrite detection both use pre-edge contents.
    always_comb begin
        first_d     = first_q;
        last_d      = last_q;
        valid_d     = valid_q;
        cursor_d    = cursor_q;
        ovf_d       = ovf_q;
        count_d     = '0;
        free_hits   = '0;
        ins_err_d   = ins_valid_i && (ins_last_i < ins_first_i) && !clear_i;
        for (int i = 0; i < DEPTH; i++) begin
            free_hits[i] = valid_q[i] && (first_q[i] == free_first_i);
        end
        free_miss_d = free_act && (free_hits == '0);
        if (clear_i) begin
            valid_d  = '0;
            cursor_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                first_d[i] = '0;
                last_d[i]  = '0;
            end
        end else begin
            if (free_act) begin
                valid_d = valid_q & ~free_hits;
            end
            // Insert is applied after free so a freed slot that is also the insert slot ends up valid.
            if (ins_ok) begin
                first_d[cursor_q] = ins_first_i;
                last_d[cursor_q]  = ins_last_i;
                valid_d[cursor_q] = 1'b1;
                cursor_d          = cursor_q + IDX_W'(1);
                if (valid_q[cursor_q]) begin
                    ovf_d = 1'b1;
                end
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            count_d = count_d + (IDX_W + 1)'(valid_d[i]);
        end
    end

    // Lookup against pre-edge state; lowest matching index wins.
    always_comb begin
        r_valid_d = q_valid_i;
        r_hit_d   = r_hit_q;
        r_idx_d   = r_idx_q;
        r_first_d = r_first_q;
        r_last_d  = r_last_q;
        found     = 1'b0;
        if (q_valid_i) begin
            r_hit_d   = 1'b0;
            r_idx_d   = '0;
            r_first_d = '0;
            r_last_d  = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (!found && valid_q[i] && (q_addr_i >= first_q[i]) && (q_addr_i <= last_q[i])) begin
                    found     = 1'b1;
                    r_hit_d   = 1'b1;
                    r_idx_d   = IDX_W'(i);
                    r_first_d = first_q[i];
                    r_last_d  = last_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                first_q[i] <= '0;
                last_q[i]  <= '0;
            end
            valid_q     <= '0;
            cursor_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            ins_err_q   <= 1'b0;
            free_miss_q <= 1'b0;
            r_valid_q   <= 1'b0;
            r_hit_q     <= 1'b0;
            r_idx_q     <= '0;
            r_first_q   <= '0;
            r_last_q    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                first_q[i] <= first_d[i];
                last_q[i]  <= last_d[i];
            end
            valid_q     <= valid_d;
            cursor_q    <= cursor_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            ins_err_q   <= ins_err_d;
            free_miss_q <= free_miss_d;
            r_valid_q   <= r_valid_d;
            r_hit_q     <= r_hit_d;
            r_idx_q     <= r_idx_d;
            r_first_q   <= r_first_d;
            r_last_q    <= r_last_d;
        end
    end

    assign ins_err_o   = ins_err_q;
    assign free_miss_o = free_miss_q;
    assign r_valid_o   = r_valid_q;
    assign r_hit_o     = r_hit_q;
    assign r_idx_o     = r_idx_q;
    assign r_first_o   = r_first_q;
    assign r_last_o    = r_last_q;
    assign count_o     = count_q;
    assign full_o      = (count_q == (IDX_W + 1)'(DEPTH));
    assign ovf_o       = ovf_q;

`ifdef OM_RT_READBACK_EN
    // Contents are zeroed on reset and clear, so this reads 0 until the first insert.
    assign last_first_o = first_q[cursor_q - IDX_W'(1)];
    assign last_last_o  = last_q[cursor_q - IDX_W'(1)];
`endif

endmodule

// File: tb/tb_om_range_table.sv
// tb/tb_om_range_table.sv - directed self-checking bench for om_range_table at DEPTH=4
module tb_om_range_table;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int IDX_W  = 2;

    logic              clk, rst, clear;
    logic              ins_valid, free_valid, q_valid;
    logic [ADDR_W-1:0] ins_first, ins_last, free_first, q_addr;
    logic              ins_err, free_miss, r_valid, r_hit, full, ovf;
    logic [IDX_W-1:0]  r_idx;
    logic [ADDR_W-1:0] r_first, r_last;
    logic [IDX_W:0]    count;
`ifdef OM_RT_READBACK_EN
    logic [ADDR_W-1:0] last_first, last_last;
`endif
    int checks = 0;
    int errors = 0;

    om_range_table #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear),
        .ins_valid_i(ins_valid), .ins_first_i(ins_first), .ins_last_i(ins_last), .ins_err_o(ins_err),
        .free_valid_i(free_valid), .free_first_i(free_first), .free_miss_o(free_miss),
        .q_valid_i(q_valid), .q_addr_i(q_addr),
        .r_valid_o(r_valid), .r_hit_o(r_hit), .r_idx_o(r_idx), .r_first_o(r_first), .r_last_o(r_last),
`ifdef OM_RT_READBACK_EN
        .last_first_o(last_first), .last_last_o(last_last),
`endif
        .count_o(count), .full_o(full), .ovf_o(ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        rst = 1'b0; clear = 1'b0; ins_valid = 1'b0; free_valid = 1'b0; q_valid = 1'b0;
    endtask

    task automatic do_insert(input logic [ADDR_W-1:0] f, input logic [ADDR_W-1:0] l);
        ins_valid = 1'b1; ins_first = f; ins_last = l;
        cyc();
    endtask

    task automatic do_query(input logic [ADDR_W-1:0] a);
        q_valid = 1'b1; q_addr = a;
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b1;
        cyc();
        checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %0h exp 0", r_valid); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
`ifdef OM_RT_READBACK_EN
        checks++; if (last_first !== 32'h0) begin errors++; $display("FAIL reset_last_first got %0h exp 0", last_first); end
`endif
        do_query(32'h100);
        checks++; if (r_valid !== 1'b1) begin errors++; $display("FAIL q100_rvalid got %0h exp 1", r_valid); end
        checks++; if (r_hit !== 1'b0) begin errors++; $display("FAIL q100_hit got %0h exp 0", r_hit); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %0h exp 0", full); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0h exp 0", ovf); end
        cyc();
        checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL rvalid_drop got %0h exp 0", r_valid); end
    endtask

    task automatic test_insert_lookup();
        do_insert(32'h1000, 32'h10FF);
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL ins_count got %0d exp 1", count); end
`ifdef OM_RT_READBACK_EN
        checks++; if (last_first !== 32'h1000 || last_last !== 32'h10FF) begin errors++; $display("FAIL readback got %0h/%0h exp 1000/10ff", last_first, last_last); end
`endif
        do_query(32'h1000);
        checks++; if (r_hit !== 1'b1 || r_idx !== 2'd0) begin errors++; $display("FAIL q1000 got hit %0h idx %0d exp 1/0", r_hit, r_idx); end
        checks++; if (r_first !== 32'h1000 || r_last !== 32'h10FF) begin errors++; $display("FAIL q1000_bounds got %0h/%0h exp 1000/10ff", r_first, r_last); end
        do_query(32'h10FF);
        checks++; if (r_hit !== 1'b1 || r_idx !== 2'd0) begin errors++; $display("FAIL q10ff got hit %0h idx %0d exp 1/0", r_hit, r_idx); end
        do_query(32'h1100);
        checks++; if (r_hit !== 1'b0 || r_idx !== 2'd0 || r_first !== 32'h0 || r_last !== 32'h0) begin
            errors++; $display("FAIL q1100 got hit %0h idx %0d first %0h last %0h exp 0/0/0/0", r_hit, r_idx, r_first, r_last); end
        cyc();
        checks++; if (r_hit !== 1'b0 || r_first !== 32'h0) begin errors++; $display("FAIL result_hold got %0h/%0h exp 0/0", r_hit, r_first); end
    endtask

    task automatic test_reject();
        do_insert(32'h20, 32'h10);
        checks++; if (ins_err !== 1'b1) begin errors++; $display("FAIL ins_err got %0h exp 1", ins_err); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL rej_count got %0d exp 1", count); end
        cyc();
        checks++; if (ins_err !== 1'b0) begin errors++; $display("FAIL ins_err_pulse got %0h exp 0", ins_err); end
        do_insert(32'h2000, 32'h2000);
        checks++; if (ins_err !== 1'b0 || count !== 3'd2) begin errors++; $display("FAIL eq_bounds got err %0h count %0d exp 0/2", ins_err, count); end
        do_query(32'h2000);
        checks++; if (r_hit !== 1'b1 || r_idx !== 2'd1) begin errors++; $display("FAIL q2000 got hit %0h idx %0d exp 1/1", r_hit, r_idx); end
    endtask

    task automatic test_wrap();
        do_insert(32'h3000, 32'h30FF);
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_early got %0h exp 0", full); end
        do_insert(32'h4000, 32'h40FF);
        checks++; if (count !== 3'd4 || full !== 1'b1 || ovf !== 1'b0) begin
            errors++; $display("FAIL full4 got count %0d full %0h ovf %0h exp 4/1/0", count, full, ovf); end
        do_insert(32'h5000, 32'h50FF);
        checks++; if (count !== 3'd4 || ovf !== 1'b1) begin errors++; $display("FAIL overwrite got count %0d ovf %0h exp 4/1", count, ovf); end
        do_query(32'h1080);
        checks++; if (r_hit !== 1'b0) begin errors++; $display("FAIL q_old got %0h exp 0", r_hit); end
        do_query(32'h5000);
        checks++; if (r_hit !== 1'b1 || r_idx !== 2'd0 || r_last !== 32'h50FF) begin
            errors++; $display("FAIL q5000 got hit %0h idx %0d last %0h exp 1/0/50ff", r_hit, r_idx, r_last); end
        clear = 1'b1;
        cyc();
        checks++; if (ovf !== 1'b1 || count !== 3'd0 || full !== 1'b0) begin
            errors++; $display("FAIL clear_sticky got ovf %0h count %0d full %0h exp 1/0/0", ovf, count, full); end
`ifdef OM_RT_READBACK_EN
        checks++; if (last_first !== 32'h0) begin errors++; $display("FAIL clear_readback got %0h exp 0", last_first); end
`endif
        do_insert(32'h800, 32'h8FF);
        do_query(32'h850);
        checks++; if (r_hit !== 1'b1 || r_idx !== 2'd0) begin errors++; $display("FAIL cursor_after_clear got hit %0h idx %0d exp 1/0", r_hit, r_idx); end
    endtask

    task automatic test_free();
        rst = 1'b1;
        cyc();
        do_insert(32'h100, 32'h1FF);
        do_insert(32'h200, 32'h2FF);
        free_valid = 1'b1; free_first = 32'h100;
        cyc();
        checks++; if (count !== 3'd1 || free_miss !== 1'b0) begin errors++; $display("FAIL free_a got count %0d miss %0h exp 1/0", count, free_miss); end
        do_query(32'h150);
        checks++; if (r_hit !== 1'b0) begin errors++; $display("FAIL q_freed got %0h exp 0", r_hit); end
        do_query(32'h250);
        checks++; if (r_hit !== 1'b1 || r_idx !== 2'd1) begin errors++; $display("FAIL q_b got hit %0h idx %0d exp 1/1", r_hit, r_idx); end
        free_valid = 1'b1; free_first = 32'hDEAD;
        cyc();
        checks++; if (free_miss !== 1'b1 || count !== 3'd1) begin errors++; $display("FAIL free_miss got %0h count %0d exp 1/1", free_miss, count); end
        cyc();
        checks++; if (free_miss !== 1'b0) begin errors++; $display("FAIL free_miss_pulse got %0h exp 0", free_miss); end
    endtask

    task automatic test_back_to_back();
        do_insert(32'h300, 32'h3FF);
        do_insert(32'h400, 32'h4FF);
        do_insert(32'h500, 32'h5FF);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL refill_count got %0d exp 4", count); end
        free_valid = 1'b1; free_first = 32'h200;
        ins_valid = 1'b1; ins_first = 32'h600; ins_last = 32'h6FF;
        q_valid = 1'b1; q_addr = 32'h250;
        cyc();
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL simul_count got %0d exp 4", count); end
        checks++; if (r_hit !== 1'b1 || r_idx !== 2'd1 || r_first !== 32'h200 || r_last !== 32'h2FF) begin
            errors++; $display("FAIL simul_query got hit %0h idx %0d %0h/%0h exp 1/1/200/2ff", r_hit, r_idx, r_first, r_last); end
        q_valid = 1'b1; q_addr = 32'h650;
        cyc();
        checks++; if (r_hit !== 1'b1 || r_idx !== 2'd1 || r_first !== 32'h600) begin
            errors++; $display("FAIL q_new got hit %0h idx %0d first %0h exp 1/1/600", r_hit, r_idx, r_first); end
        do_query(32'h250);
        checks++; if (r_hit !== 1'b0) begin errors++; $display("FAIL q_replaced got %0h exp 0", r_hit); end
        clear = 1'b1; q_valid = 1'b1; q_addr = 32'h550;
        ins_valid = 1'b1; ins_first = 32'h700; ins_last = 32'h7FF;
        cyc();
        checks++; if (r_hit !== 1'b1 || r_idx !== 2'd0 || r_first !== 32'h500) begin
            errors++; $display("FAIL clear_query got hit %0h idx %0d first %0h exp 1/0/500", r_hit, r_idx, r_first); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL clear_count got %0d exp 0", count); end
        do_query(32'h750);
        checks++; if (r_hit !== 1'b0) begin errors++; $display("FAIL clear_ins_ignored got %0h exp 0", r_hit); end
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; ins_valid = 1'b0; free_valid = 1'b0; q_valid = 1'b0;
        ins_first = '0; ins_last = '0; free_first = '0; q_addr = '0;
        test_reset();
        test_insert_lookup();
        test_reject();
        test_wrap();
        test_free();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/om_range_table.md
Name: om_range_table

Overview:
- Parametrised table of memory-object address ranges {first, last}, inclusive bounds.
- Used by the memory-safety checker to decide whether a data address falls inside any live object.
- Successor of the fixed 32-entry cursor buffer. Adds per-entry valid bits, free-by-base-address, a registered lookup that returns the matching index and bounds, occupancy/full/overwrite status, and malformed-range rejection.

Parameters:
- DEPTH, 32, number of entries; power of two, >= 2.
- ADDR_W, 32, address width in bits.
- IDX_W, $clog2(DEPTH), index width; derived, not overridden.

Ports:
- clk_i  in  1  single clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- clear_i  in  1  synchronous flush: invalidates all entries, cursor=0, count=0, sticky flags kept.
- ins_valid_i  in  1  insert request (single-cycle pulse per insert).
- ins_first_i  in  ADDR_W  inclusive lower bound of inserted object.
- ins_last_i  in  ADDR_W  inclusive upper bound of inserted object.
- ins_err_o  out  1  registered; 1 for one cycle after a rejected insert (last < first).
- free_valid_i  in  1  free request.
- free_first_i  in  ADDR_W  base address of object to free.
- free_miss_o  out  1  registered; 1 for one cycle after a free that matched no valid entry.
- q_valid_i  in  1  lookup request.
- q_addr_i  in  ADDR_W  address to check.
- r_valid_o  out  1  lookup result valid, exactly 1 cycle after q_valid_i.
- r_hit_o  out  1  q_addr inside at least one valid range.
- r_idx_o  out  IDX_W  lowest matching index; 0 on miss.
- r_first_o  out  ADDR_W  bounds of the matched entry; 0 on miss.
- r_last_o  out  ADDR_W  bounds of the matched entry; 0 on miss.
- count_o  out  IDX_W+1  number of valid entries.
- full_o  out  1  count_o == DEPTH.
- ovf_o  out  1  sticky; set when an insert overwrote a valid entry.

Behaviour:
- Reset (rst_i=1 at clock edge):
  - All valid bits 0; entry contents 0; cursor 0; count 0.
  - ovf_o, ins_err_o, free_miss_o, r_valid_o, r_hit_o all 0; r_idx/r_first/r_last 0.
  - Reset overrides every other input in that cycle, including mid-operation.
- Insert (ins_valid_i=1 and ins_last_i >= ins_first_i):
  - mem[cursor] <= {first, last}; valid[cursor] <= 1; cursor <= cursor+1, wrapping DEPTH-1 -> 0.
  - If valid[cursor] was already 1: ovf_o <= 1, count unchanged.
  - Otherwise count +1.
  - Equal bounds (single-byte object) are legal.
- Rejected insert (last < first): no table or cursor change; ins_err_o=1 next cycle.
- Free (free_valid_i=1):
  - Clears valid bit of every valid entry with first == free_first_i; count decrements by the number cleared.
  - No match: free_miss_o=1 next cycle.
  - Cursor never moves on free; freed holes are reused only when the cursor wraps onto them.
- Simultaneous insert and free in one cycle:
  - Free matching is evaluated on pre-edge contents.
  - If the freed slot is also the insert slot, the insert wins: slot valid with new data, count net +0 for that slot.
  - count_o = old + inserts_to_empty_slots - frees_of_slots_not_being_written.
- Lookup:
  - Inclusive compare first <= q_addr <= last, unsigned, against state before the same-edge insert/free/clear.
  - Only valid entries match.
  - Priority: lowest index.
  - Result registered; latency exactly 1; one query per cycle accepted (fully pipelined).
  - r_valid_o=0 leaves other result outputs at their previous values.
- clear_i:
  - Same-cycle insert and free are ignored.
  - A same-cycle lookup still returns its result computed on pre-clear state.
- Wrap-around: after DEPTH accepted inserts the cursor returns to 0. full_o=1 only when all entries are valid.

Optional Feature:
- Macro OM_RT_READBACK_EN.
- Defined:
  - Adds outputs last_first_o / last_last_o (ADDR_W each) giving bounds at index cursor-1 (most recent insert, wrapping 0 -> DEPTH-1).
  - Reads 0 after reset/clear.
  - Combinational from table state.
- Undefined: ports absent; no other behaviour change.

Test Plan:
- Reset then query 0x100 -> r_valid=1 after 1 cycle, r_hit=0, count=0, full=0, ovf=0.
- Insert {0x1000,0x10FF}; query 0x1000, 0x10FF, 0x1100 -> hit idx0 bounds 0x1000/0x10FF; hit idx0; miss.
- Insert {0x20,0x10} -> ins_err pulse 1 cycle; count unchanged; cursor unchanged (next valid insert lands at its slot).
- DEPTH=4: 5 inserts -> full after 4th; 5th overwrites idx0, ovf=1 sticky, count=4; query into overwritten old range misses.
- Insert A at idx0 and B at idx1, free A.first -> count 1, query in A misses. Free 0xDEAD -> free_miss pulse.
- Same cycle: free idx(cursor) entry + insert new, plus query -> insert wins, count unchanged, query sees old contents; clear_i with lookup -> result pre-clear, count 0 next.
